// File: rtl/ir_nav_pkg.sv
// Shared definitions for the IR obstacle-avoidance navigator.
// Holds the state encoding, the motor command bit layout and the default
// cycle constants used by the top level and its testbench.
package ir_nav_pkg;

  localparam int unsigned NAV_STATE_W = 3;
  localparam int unsigned IR_W        = 4;

  typedef enum logic [NAV_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FWD     = 3'd1,
    ST_BRAKE   = 3'd2,
    ST_REVERSE = 3'd3,
    ST_TURN    = 3'd4,
    ST_BLOCKED = 3'd5
  } nav_state_t;

  // Motor command vector: {en_l, en_r, dir_l, dir_r}
  localparam int unsigned MOTOR_W     = 4;
  localparam int unsigned MOTOR_EN_L  = 3;
  localparam int unsigned MOTOR_EN_R  = 2;
  localparam int unsigned MOTOR_DIR_L = 1;
  localparam int unsigned MOTOR_DIR_R = 0;

  // Defaults for a 100 MHz clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 100000;
  localparam int unsigned DEF_BRAKE_CYCLES    = 10000000;
  localparam int unsigned DEF_REVERSE_CYCLES  = 50000000;
  localparam int unsigned DEF_TURN_CYCLES     = 30000000;
  localparam int unsigned DEF_TIMER_W         = 32;

  // Motor command for a given state; turn_right selects pivot direction.
  function automatic logic [MOTOR_W-1:0] motor_cmd(input nav_state_t st,
                                                   input logic       turn_right);
    logic [MOTOR_W-1:0] cmd;
    cmd = '0;
    case (st)
      ST_FWD: begin
        cmd[MOTOR_EN_L]  = 1'b1;
        cmd[MOTOR_EN_R]  = 1'b1;
        cmd[MOTOR_DIR_L] = 1'b1;
        cmd[MOTOR_DIR_R] = 1'b1;
      end
      ST_REVERSE: begin
        cmd[MOTOR_EN_L]  = 1'b1;
        cmd[MOTOR_EN_R]  = 1'b1;
      end
      ST_TURN: begin
        cmd[MOTOR_EN_L]  = 1'b1;
        cmd[MOTOR_EN_R]  = 1'b1;
        cmd[MOTOR_DIR_L] = turn_right;
        cmd[MOTOR_DIR_R] = ~turn_right;
      end
      default: cmd = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/debounce_vec.sv
// Per-bit debouncer for a vector of synchronised sensor inputs.
// A bit's debounced value follows raw only after raw has differed from it
// for CYCLES consecutive clocks.
// Ports: clock, reset_n (sync, active-low), raw[WIDTH], db[WIDTH] (registered).
module debounce_vec #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db
);

  localparam int unsigned      CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            db_q,  db_d;

  // Count while differing; commit raw and clear on the last count
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (raw[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/ir_obstacle_nav.sv
// Reflexive obstacle-avoidance controller for the rover.
// Debounces front/back IR proximity vectors and sequences
// FWD -> BRAKE -> REVERSE -> TURN -> FWD, falling into BLOCKED when boxed in.
// Ports:
//   clock, reset_n (sync, active-low), enable (run permission)
//   ir_front[3:0] (bit3..2 left, bit1..0 right), ir_back[3:0], 1 = obstacle
//   motor_en_l/r, motor_dir_l/r (1 = forward) to the H-bridge stage
//   obstacle_front/back (OR of debounced bits), nav_state (state code)
module ir_obstacle_nav
  import ir_nav_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BRAKE_CYCLES    = DEF_BRAKE_CYCLES,
  parameter int unsigned REVERSE_CYCLES  = DEF_REVERSE_CYCLES,
  parameter int unsigned TURN_CYCLES     = DEF_TURN_CYCLES,
  parameter int unsigned TIMER_W         = DEF_TIMER_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [IR_W-1:0]        ir_front,
  input  logic [IR_W-1:0]        ir_back,
  output logic                   motor_en_l,
  output logic                   motor_en_r,
  output logic                   motor_dir_l,
  output logic                   motor_dir_r,
  output logic                   obstacle_front,
  output logic                   obstacle_back,
  output logic [NAV_STATE_W-1:0] nav_state
);

  localparam logic [TIMER_W-1:0] BRAKE_LAST   = TIMER_W'(BRAKE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REVERSE_LAST = TIMER_W'(REVERSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_LAST    = TIMER_W'(TURN_CYCLES - 1);

  logic [IR_W-1:0]    front_db, back_db;
  logic               front_hit, back_hit;

  nav_state_t         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               turn_right_q, turn_right_d;
  logic [MOTOR_W-1:0] motor_q, motor_d;
  logic               obst_front_q, obst_front_d;
  logic               obst_back_q, obst_back_d;

  debounce_vec #(.WIDTH(IR_W), .CYCLES(DEBOUNCE_CYCLES)) u_db_front (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (ir_front),
    .db      (front_db)
  );

  debounce_vec #(.WIDTH(IR_W), .CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (ir_back),
    .db      (back_db)
  );

  assign front_hit = |front_db;
  assign back_hit  = |back_db;

  // Next-state, timer and output decode
  always_comb begin
    state_d      = state_q;
    turn_right_d = turn_right_q;
    obst_front_d = front_hit;
    obst_back_d  = back_hit;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FWD;
        ST_FWD: begin
          if (front_hit) begin
            state_d      = ST_BRAKE;
            // Obstacle on the left side means pivot right
            turn_right_d = |front_db[IR_W-1:IR_W/2];
          end
        end
        ST_BRAKE: begin
          if (timer_q == BRAKE_LAST) begin
            state_d = back_hit ? ST_BLOCKED : ST_REVERSE;
          end
        end
        ST_REVERSE: begin
          if (back_hit) begin
            state_d = ST_BLOCKED;
          end else if (timer_q == REVERSE_LAST) begin
            state_d = ST_TURN;
          end
        end
        ST_TURN: begin
          if (timer_q == TURN_LAST) begin
            state_d = ST_FWD;
          end
        end
        ST_BLOCKED: begin
          if (!front_hit) begin
            state_d = ST_FWD;
          end else if (!back_hit) begin
            state_d = ST_REVERSE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Restart on every state change; saturate rather than wrap
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TIMER_W'(1);
    end else begin
      timer_d = timer_q;
    end

    motor_d = motor_cmd(state_d, turn_right_d);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      turn_right_q <= 1'b0;
      motor_q      <= '0;
      obst_front_q <= 1'b0;
      obst_back_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      turn_right_q <= turn_right_d;
      motor_q      <= motor_d;
      obst_front_q <= obst_front_d;
      obst_back_q  <= obst_back_d;
    end
  end

  assign motor_en_l     = motor_q[MOTOR_EN_L];
  assign motor_en_r     = motor_q[MOTOR_EN_R];
  assign motor_dir_l    = motor_q[MOTOR_DIR_L];
  assign motor_dir_r    = motor_q[MOTOR_DIR_R];
  assign obstacle_front = obst_front_q;
  assign obstacle_back  = obst_back_q;
  assign nav_state      = state_q;

endmodule

// File: tb/tb_ir_obstacle_nav.sv
// Directed testbench for ir_obstacle_nav with short cycle parameters
// (DEBOUNCE=4, BRAKE=3, REVERSE=8, TURN=6).
module tb_ir_obstacle_nav;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [3:0] ir_front;
  logic [3:0] ir_back;
  logic       motor_en_l, motor_en_r, motor_dir_l, motor_dir_r;
  logic       obstacle_front, obstacle_back;
  logic [2:0] nav_state;
  logic [3:0] mot;

  int total = 0;
  int bad   = 0;

  ir_obstacle_nav #(
    .DEBOUNCE_CYCLES (4),
    .BRAKE_CYCLES    (3),
    .REVERSE_CYCLES  (8),
    .TURN_CYCLES     (6),
    .TIMER_W         (32)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .ir_front       (ir_front),
    .ir_back        (ir_back),
    .motor_en_l     (motor_en_l),
    .motor_en_r     (motor_en_r),
    .motor_dir_l    (motor_dir_l),
    .motor_dir_r    (motor_dir_r),
    .obstacle_front (obstacle_front),
    .obstacle_back  (obstacle_back),
    .nav_state      (nav_state)
  );

  assign mot = {motor_en_l, motor_en_r, motor_dir_l, motor_dir_r};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; ir_front = 4'h0; ir_back = 4'h0;
    tick(2);
    total++; if (nav_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", nav_state); end
    total++; if (mot !== 4'b0000) begin bad++; $display("FAIL reset_motors: got %b want 0000", mot); end
    total++; if ({obstacle_front, obstacle_back} !== 2'b00) begin bad++; $display("FAIL reset_obst: got %b want 00", {obstacle_front, obstacle_back}); end
    reset_n = 1'b1; enable = 1'b1;
    tick(1);
    total++; if (nav_state !== 3'd1) begin bad++; $display("FAIL start_fwd_state: got %0d want 1", nav_state); end
    total++; if (mot !== 4'b1111) begin bad++; $display("FAIL start_fwd_motors: got %b want 1111", mot); end
  endtask

  task automatic test_right_hit;
    // 3-cycle glitch must be rejected
    ir_front = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (nav_state !== 3'd1 || obstacle_front !== 1'b0) begin bad++; $display("FAIL glitch_%0d: got state=%0d obst=%b want 1/0", i, nav_state, obstacle_front); end
    end
    ir_front = 4'b0000;
    tick(2);
    total++; if (nav_state !== 3'd1 || obstacle_front !== 1'b0) begin bad++; $display("FAIL glitch_after: got state=%0d obst=%b want 1/0", nav_state, obstacle_front); end
    // Left-side hit held: BRAKE on the 5th edge
    ir_front = 4'b0100;
    tick(4);
    total++; if (nav_state !== 3'd1) begin bad++; $display("FAIL pre_brake: got %0d want 1", nav_state); end
    tick(1);
    total++; if (nav_state !== 3'd2 || mot !== 4'b0000) begin bad++; $display("FAIL brake: got state=%0d mot=%b want 2/0000", nav_state, mot); end
    total++; if (obstacle_front !== 1'b1) begin bad++; $display("FAIL obst_front: got %b want 1", obstacle_front); end
    ir_front = 4'b0000;
    tick(2);
    total++; if (nav_state !== 3'd2) begin bad++; $display("FAIL brake_dwell: got %0d want 2", nav_state); end
    tick(1);
    total++; if (nav_state !== 3'd3 || mot !== 4'b1100) begin bad++; $display("FAIL reverse: got state=%0d mot=%b want 3/1100", nav_state, mot); end
    tick(7);
    total++; if (nav_state !== 3'd3) begin bad++; $display("FAIL reverse_dwell: got %0d want 3", nav_state); end
    tick(1);
    total++; if (nav_state !== 3'd4 || mot !== 4'b1110) begin bad++; $display("FAIL turn_right: got state=%0d mot=%b want 4/1110", nav_state, mot); end
    tick(5);
    total++; if (nav_state !== 3'd4) begin bad++; $display("FAIL turn_dwell: got %0d want 4", nav_state); end
    tick(1);
    total++; if (nav_state !== 3'd1 || mot !== 4'b1111) begin bad++; $display("FAIL turn_to_fwd: got state=%0d mot=%b want 1/1111", nav_state, mot); end
  endtask

  task automatic test_left_turn;
    ir_front = 4'b0001;
    tick(5);
    total++; if (nav_state !== 3'd2) begin bad++; $display("FAIL lt_brake: got %0d want 2", nav_state); end
    ir_front = 4'b0000;
    tick(3 + 8);
    total++; if (nav_state !== 3'd4 || mot !== 4'b1101) begin bad++; $display("FAIL turn_left: got state=%0d mot=%b want 4/1101", nav_state, mot); end
    tick(6);
    total++; if (nav_state !== 3'd1) begin bad++; $display("FAIL lt_fwd: got %0d want 1", nav_state); end
  endtask

  task automatic test_back_block;
    ir_front = 4'b0100;
    tick(5 + 3);
    total++; if (nav_state !== 3'd3) begin bad++; $display("FAIL bb_reverse: got %0d want 3", nav_state); end
    ir_back = 4'b1000;
    tick(4);
    total++; if (nav_state !== 3'd3 || obstacle_back !== 1'b0) begin bad++; $display("FAIL bb_pre: got state=%0d obst_b=%b want 3/0", nav_state, obstacle_back); end
    tick(1);
    total++; if (nav_state !== 3'd5 || mot !== 4'b0000) begin bad++; $display("FAIL blocked: got state=%0d mot=%b want 5/0000", nav_state, mot); end
    total++; if (obstacle_back !== 1'b1) begin bad++; $display("FAIL obst_back: got %b want 1", obstacle_back); end
    tick(2);
    total++; if (nav_state !== 3'd5) begin bad++; $display("FAIL blocked_hold: got %0d want 5", nav_state); end
    ir_front = 4'b0000;
    tick(4);
    total++; if (nav_state !== 3'd5) begin bad++; $display("FAIL blocked_pre_clear: got %0d want 5", nav_state); end
    tick(1);
    total++; if (nav_state !== 3'd1 || mot !== 4'b1111) begin bad++; $display("FAIL blocked_to_fwd: got state=%0d mot=%b want 1/1111", nav_state, mot); end
    ir_back = 4'b0000;
    tick(5);
    total++; if (nav_state !== 3'd1 || obstacle_back !== 1'b0) begin bad++; $display("FAIL back_clear: got state=%0d obst_b=%b want 1/0", nav_state, obstacle_back); end
  endtask

  task automatic test_abort;
    // enable dropped mid-turn
    ir_front = 4'b0100;
    tick(5);
    ir_front = 4'b0000;
    tick(3 + 8 + 2);
    total++; if (nav_state !== 3'd4) begin bad++; $display("FAIL ab_turn: got %0d want 4", nav_state); end
    enable = 1'b0;
    tick(1);
    total++; if (nav_state !== 3'd0 || mot !== 4'b0000) begin bad++; $display("FAIL disable_idle: got state=%0d mot=%b want 0/0000", nav_state, mot); end
    enable = 1'b1;
    tick(1);
    total++; if (nav_state !== 3'd1) begin bad++; $display("FAIL reenable_fwd: got %0d want 1", nav_state); end
    // reset mid-reverse with front still held
    ir_front = 4'b0100;
    tick(5 + 3 + 2);
    total++; if (nav_state !== 3'd3 || obstacle_front !== 1'b1) begin bad++; $display("FAIL ab_reverse: got state=%0d obst_f=%b want 3/1", nav_state, obstacle_front); end
    reset_n = 1'b0;
    tick(1);
    total++; if (nav_state !== 3'd0 || mot !== 4'b0000) begin bad++; $display("FAIL reset_abort: got state=%0d mot=%b want 0/0000", nav_state, mot); end
    total++; if (obstacle_front !== 1'b0) begin bad++; $display("FAIL reset_obst_clear: got %b want 0", obstacle_front); end
    ir_front = 4'b0000;
    reset_n  = 1'b1;
    tick(1);
    total++; if (nav_state !== 3'd1) begin bad++; $display("FAIL post_reset_fwd: got %0d want 1", nav_state); end
  endtask

  task automatic test_both_blocked;
    ir_front = 4'b1111;
    ir_back  = 4'b1111;
    tick(5);
    total++; if (nav_state !== 3'd2) begin bad++; $display("FAIL both_brake: got %0d want 2", nav_state); end
    tick(2);
    total++; if (nav_state !== 3'd2) begin bad++; $display("FAIL both_brake_dwell: got %0d want 2", nav_state); end
    tick(1);
    total++; if (nav_state !== 3'd5 || mot !== 4'b0000) begin bad++; $display("FAIL both_blocked: got state=%0d mot=%b want 5/0000", nav_state, mot); end
    tick(5);
    total++; if (nav_state !== 3'd5 || {obstacle_front, obstacle_back} !== 2'b11) begin bad++; $display("FAIL both_hold: got state=%0d obst=%b want 5/11", nav_state, {obstacle_front, obstacle_back}); end
    ir_front = 4'b0000;
    ir_back  = 4'b0000;
    tick(5);
    total++; if (nav_state !== 3'd1) begin bad++; $display("FAIL both_release: got %0d want 1", nav_state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_right_hit();
    test_left_turn();
    test_back_block();
    test_abort();
    test_both_blocked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
